// File: rtl/counter_rr_sched.sv
// counter_rr_sched: round-robin owner of one shared free-running counter.
// A granted requester releases the counter (drives its active-low reset high)
// until the counter reaches the latched interval, then gets a one-cycle done.
//
// Handshake: req_i[n] is a level request held until done_o[n]; dropping it
// while owning the counter aborts the job (no done). len_i is sampled only on
// the grant edge. grant_o/done_o/busy_o are registered; cnt_rstn_o is
// combinational. state_dbg mirrors the FSM state (1 = RUN).
module counter_rr_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] len_i,
    input  logic [WIDTH-1:0]      cnt_out_i,
    output logic                  cnt_rstn_o,
    output logic [NREQ-1:0]       grant_o,
    output logic [NREQ-1:0]       done_o,
    output logic                  busy_o,
    output logic                  state_dbg
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [WIDTH-1:0] len_q, len_n;
    logic [NREQ-1:0]  grant_n, done_n;
    logic             busy_n;

    logic             owner_req;
    logic             at_len;
    logic             found;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    win;

    // ptr doubles as the owner index while in RUN
    assign owner_req  = req_i[ptr];
    assign at_len     = (cnt_out_i == len_q);
    assign cnt_rstn_o = (state == RUN) && owner_req && !at_len;
    assign state_dbg  = (state == RUN);

    // Round-robin pick: first pending requester after the last granted one
    always_comb begin
        found = 1'b0;
        cand  = ptr;
        win   = ptr;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        len_n   = len_q;
        grant_n = grant_o;
        done_n  = '0;
        busy_n  = busy_o;
        case (state)
            IDLE: begin
                grant_n = '0;
                busy_n  = 1'b0;
                if (found) begin
                    state_n      = RUN;
                    ptr_n        = win;
                    len_n        = len_i[int'(win)*WIDTH +: WIDTH];
                    grant_n[win] = 1'b1;
                    busy_n       = 1'b1;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    // abort wins over completion; ptr keeps the aborted owner
                    state_n = IDLE;
                    grant_n = '0;
                    busy_n  = 1'b0;
                end else if (at_len) begin
                    state_n     = IDLE;
                    grant_n     = '0;
                    busy_n      = 1'b0;
                    done_n[ptr] = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            ptr     <= PW'(NREQ - 1);
            len_q   <= '0;
            grant_o <= '0;
            done_o  <= '0;
            busy_o  <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            len_q   <= len_n;
            grant_o <= grant_n;
            done_o  <= done_n;
            busy_o  <= busy_n;
        end
    end

endmodule

// File: tb/tb_counter_rr_sched.sv
// Bench for counter_rr_sched: directed scenarios with literal expectations,
// then random traffic, all continuously compared against a job-level model.
module tb_counter_rr_sched;
    localparam int NREQ = 4;
    localparam int W    = 4;

    // ---------------- clock / reset / DUT ----------------
    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic [NREQ-1:0] req  = '0;
    logic [NREQ*W-1:0] len = '0;
    logic [W-1:0]    cnt  = '0;
    logic            cnt_rstn;
    logic [NREQ-1:0] grant, done;
    logic            busy, state_dbg;

    always #5 clk = ~clk;

    counter_rr_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .req_i(req), .len_i(len), .cnt_out_i(cnt),
        .cnt_rstn_o(cnt_rstn), .grant_o(grant), .done_o(done), .busy_o(busy),
        .state_dbg(state_dbg)
    );

    // shared counter: clears when its rstn is low, otherwise increments
    always @(posedge clk) begin
        if (cnt_rstn === 1'b1) cnt <= cnt + 1'b1;
        else cnt <= '0;
    end

    // ---------------- scoreboard bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- job-level reference model ----------------
    // A job owns the counter from its grant; 'elapsed' is how many counts the
    // job has been given, which is exactly what the shared counter must show.
    bit              m_valid   = 0;
    bit              m_busy    = 0;
    int              m_owner   = 0;
    int              m_len     = 0;
    int              m_elapsed = 0;
    int              m_last    = NREQ - 1;
    logic [NREQ-1:0] m_grant   = '0;
    logic [NREQ-1:0] m_done    = '0;

    function automatic bit model_release();
        return m_busy && req[m_owner] && (m_elapsed != m_len);
    endfunction

    always @(posedge clk) begin : model
        bit rel;
        int n;
        rel = model_release();
        n = 0;
        if (!rstn) begin
            m_valid = 1; m_busy = 0; m_grant = '0; m_done = '0; m_last = NREQ - 1;
        end else if (m_valid) begin
            m_done = '0;
            if (m_busy) begin
                if (!req[m_owner]) begin
                    m_busy = 0; m_grant = '0;
                end else if (m_elapsed == m_len) begin
                    m_busy = 0; m_grant = '0; m_done[m_owner] = 1'b1;
                end
            end else if (req != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    n = (m_last + k) % NREQ;
                    if (req[n]) break;
                end
                m_owner = n; m_last = n; m_len = int'(len[n*W +: W]);
                m_busy = 1; m_grant = '0; m_grant[n] = 1'b1;
            end
        end
        m_elapsed = rel ? m_elapsed + 1 : 0;
    end

    // compare process: every cycle once reset has been seen
    always @(negedge clk) begin
        if (m_valid) begin
            check("grant", grant, m_grant);
            check("done", done, m_done);
            check("busy", busy, m_busy);
            check("state_dbg", state_dbg, m_busy);
            check("cnt", cnt, m_elapsed);
            check("cnt_rstn", cnt_rstn, model_release());
            check("grant_done_excl", (|grant) && (|done), 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // ---------------- directed + random stimulus ----------------
    int      seen[$];
    int      order[$];
    int      gtimes[$];
    int      busy_cycles, cyc, gcyc, dcyc, maxc;
    bit      got_done, hit;
    logic [NREQ-1:0] prev;

    initial begin
        // 1: reset with a request pending, then first edge after release grants
        rstn = 1'b0; req = 4'b0001; len = 16'h0003;
        tick(); tick(); tick();
        check("t1_grant_rst", grant, 0);
        check("t1_done_rst", done, 0);
        check("t1_busy_rst", busy, 0);
        check("t1_cnt_rstn_rst", cnt_rstn, 0);
        rstn = 1'b1;
        tick();
        check("t1_grant_first", grant, 4'b0001);
        check("t1_busy_first", busy, 1);
        req = '0;
        tick(); tick();

        // 2: single job len=5
        do_reset();
        len = 16'h0005; req = 4'b0001;
        busy_cycles = 0; got_done = 0; seen.delete();
        for (int c = 0; c < 40 && !got_done; c++) begin
            tick();
            if (busy) busy_cycles++;
            if (cnt != 0) seen.push_back(int'(cnt));
            if (done != 0) begin
                got_done = 1;
                check("t2_done", done, 4'b0001);
                check("t2_cnt_at_done", cnt, 0);
                req = '0;
            end
        end
        check("t2_done_seen", got_done, 1);
        check("t2_seq_len", seen.size(), 5);
        for (int i = 0; i < 5; i++)
            check("t2_seq", (seen.size() > i) ? seen[i] : 32'hff, i + 1);
        check("t2_busy_cycles", busy_cycles, 6);
        tick();
        check("t2_done_one_cycle", done, 0);

        // 3: all four requesting, len=2 each
        do_reset();
        len = 16'h2222; req = 4'b1111;
        prev = '0; cyc = 0; order.delete(); gtimes.delete();
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            tick();
            cyc++;
            if (grant != 0 && prev == 0) begin
                order.push_back(oh_idx(grant));
                gtimes.push_back(cyc);
            end
            prev = grant;
        end
        req = '0;
        check("t3_grants", order.size(), 5);
        for (int i = 0; i < 5; i++)
            check("t3_order", (order.size() > i) ? order[i] : -1, i % NREQ);
        for (int i = 1; i < 5; i++)
            check("t3_period", (gtimes.size() > i) ? gtimes[i] - gtimes[i-1] : -1, 4);
        tick(); tick();

        // 4a: len=0 on req2
        do_reset();
        len = 16'h0000; req = 4'b0100;
        tick();
        check("t4a_grant", grant, 4'b0100);
        check("t4a_cnt_g", cnt, 0);
        check("t4a_cnt_rstn", cnt_rstn, 0);
        tick();
        check("t4a_done", done, 4'b0100);
        check("t4a_grant_off", grant, 0);
        check("t4a_cnt_d", cnt, 0);
        req = '0;
        tick();
        check("t4a_done_off", done, 0);

        // 4b: len=15 on req1 (maximum, no wrap)
        do_reset();
        len = 16'h00F0; req = 4'b0010;
        maxc = 0; cyc = 0; gcyc = -1; dcyc = -100; got_done = 0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            tick();
            cyc++;
            if (grant != 0 && gcyc < 0) gcyc = cyc;
            if (int'(cnt) > maxc) maxc = int'(cnt);
            if (done != 0) begin
                got_done = 1; dcyc = cyc;
                check("t4b_done", done, 4'b0010);
                check("t4b_cnt_at_done", cnt, 0);
                req = '0;
            end
        end
        check("t4b_done_seen", got_done, 1);
        check("t4b_max", maxc, 15);
        check("t4b_latency", dcyc - gcyc, 16);

        // 5: abort req3 (len=8) after counter reads 3, req0 waiting
        do_reset();
        len = 16'h8001; req = 4'b1000;
        tick();
        check("t5_grant", grant, 4'b1000);
        req = 4'b1001;
        hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin
            tick();
            if (cnt == 3) hit = 1;
        end
        check("t5_reached3", hit, 1);
        req = 4'b0001;
        #1;
        check("t5_cnt_rstn_now", cnt_rstn, 0);
        tick();
        check("t5_grant_off", grant, 0);
        check("t5_busy_off", busy, 0);
        check("t5_no_done", done, 0);
        check("t5_cnt_clr", cnt, 0);
        tick();
        check("t5_next_grant", grant, 4'b0001);
        got_done = 0;
        for (int c = 0; c < 10 && !got_done; c++) begin
            tick();
            if (done != 0) begin got_done = 1; req = '0; end
        end
        check("t5_req0_done", got_done, 1);

        // 6: reset mid-RUN with counter at 4
        do_reset();
        len = 16'h0922; req = 4'b0100;
        tick();
        check("t6_grant", grant, 4'b0100);
        req = 4'b0111;
        hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin
            tick();
            if (cnt == 4) hit = 1;
        end
        check("t6_reached4", hit, 1);
        rstn = 1'b0;
        tick();
        check("t6_grant_rst", grant, 0);
        check("t6_busy_rst", busy, 0);
        check("t6_done_rst", done, 0);
        check("t6_cnt_rstn_rst", cnt_rstn, 0);
        check("t6_cnt_step", cnt, 5);
        tick();
        check("t6_cnt_clr", cnt, 0);
        rstn = 1'b1;
        tick();
        check("t6_grant_after", grant, 4'b0001);
        req = '0;
        tick(); tick();

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            tick();
            rstn = ($urandom_range(0, 299) != 0);
            for (int n = 0; n < NREQ; n++)
                len[n*W +: W] = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            for (int n = 0; n < NREQ; n++) begin
                if (!req[n]) begin
                    if ($urandom_range(0, 3) == 0) req[n] = 1'b1;
                end else if (m_done[n]) begin
                    if ($urandom_range(0, 3) != 0) req[n] = 1'b0;
                end else if (m_busy && m_owner == n && $urandom_range(0, 39) == 0) begin
                    req[n] = 1'b0;
                end
            end
        end
        rstn = 1'b1;
        req  = '0;
        for (int c = 0; c < 20; c++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_rr_sched.md
Name: counter_rr_sched

Overview:
- Round-robin scheduler that shares one free-running `counter` instance, 4-bit by default, between NREQ requesters.
- Each requester asks for an interval of `len` counts.
- The scheduler grants one requester at a time and releases the counter by driving the counter's active-low reset.
- It watches the counter output and pulses a per-requester done when the interval elapses.
- It sits between requesting blocks and the shared counter; it is the only driver of that counter's reset.

Parameters:
- NREQ, 4: number of requesters, at least 2.
- WIDTH, 4: counter width; the legal interval is 0 to 2^WIDTH-1.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rstn, input, 1: synchronous active-low reset.
- req_i, input, NREQ: level request per requester; held high until that requester's done_o pulse.
- len_i, input, NREQ*WIDTH: requested interval; requester n uses bits [n*WIDTH +: WIDTH]; sampled only at grant.
- cnt_out_i, input, WIDTH: `out` of the shared counter.
- cnt_rstn_o, output, 1: drives the counter's `rstn`; combinational.
- grant_o, output, NREQ: one-hot current owner; registered; zero when idle.
- done_o, output, NREQ: one-hot, one-cycle completion pulse; registered.
- busy_o, output, 1: high while in RUN; registered.

Behaviour:
- Shared counter contract: on each clk edge, out becomes 0 if its rstn is low, otherwise out+1 modulo 2^WIDTH.
- States are IDLE and RUN.
  - Registers: ptr (index of the last granted requester) and len_q (latched interval).
- Reset (rstn=0 at an edge):
  - state=IDLE, grant_o=0, done_o=0, busy_o=0, len_q=0, ptr=NREQ-1.
  - cnt_rstn_o=0 follows from state.
  - rstn overrides everything, including mid-RUN. Reset produces no done pulse, and the counter is cleared on the following edge.
- cnt_rstn_o = (state==RUN) && req_i[owner] && (cnt_out_i != len_q).
  - The counter is held at 0 whenever the scheduler is idle.
- IDLE, when any req_i is high at an edge:
  - Pick the first requester with req_i set, scanning ptr+1, ptr+2, ... modulo NREQ.
  - grant_o = onehot(winner), ptr = winner, len_q = len_i slice of winner.
  - state = RUN, busy_o = 1.
  - No requests: remain IDLE.
- RUN, normal completion: cnt_out_i == len_q with req_i[owner] still high.
  - cnt_rstn_o is low in that cycle.
  - At the next edge: done_o[owner]=1 for exactly one cycle, grant_o=0, busy_o=0, state=IDLE. The counter clears to 0 on the same edge.
- Latency:
  - Grant is registered at edge G; the counter reads L after edge G+L; done_o is high after edge G+L+1.
  - busy_o is high for L+1 cycles.
  - len=0: done after edge G+1; the counter never leaves 0.
- RUN, abort: req_i[owner] drops before completion.
  - cnt_rstn_o goes low immediately.
  - At the next edge: state=IDLE, grant_o=0, busy_o=0, no done pulse. ptr keeps the aborted owner.
  - If req_i[owner] drops in the same cycle as cnt_out_i==len_q, the abort rule takes priority: no done.
- Idle gap between jobs: the edge that ends RUN never grants. At least one IDLE cycle, with the counter at 0, separates consecutive grants.
  - Arbitration is therefore always evaluated with cnt_out_i==0.
- Fairness: a requester that holds req_i high through and after its done pulse is re-granted only if no other requester is pending. Every pending requester is served within NREQ grants.
- Requests arriving while RUN wait; they are not queued beyond their level req_i.
- len_i changes after grant have no effect on the current job.
- Wrap-around: len_q=2^WIDTH-1 is legal.
  - The counter stops at its maximum and never wraps.
  - 0 ≤ cnt_out_i ≤ len_q always holds during RUN.
- done_o and grant_o are never both nonzero in the same cycle.

Test Plan:
1. Reset with req_i=4'b0001 held → grant_o=0, done_o=0, busy_o=0, cnt_rstn_o=0. After rstn rises, grant_o=4'b0001 on the first edge.
2. Single job, req0 with len=5 → counter outputs 1,2,3,4,5. busy_o is high for 6 cycles. done_o=4'b0001 for one cycle, after which the counter reads 0.
3. All four requesting, len=2 each, requests held until done → grant order 0,1,2,3,0. Each job lasts 3 busy cycles plus 1 idle cycle.
4. Edge lengths:
   - req2 with len=0 → done_o=4'b0100 one cycle after grant; cnt_out_i stays 0 throughout.
   - req1 with len=15 → counter reaches 15 and never wraps; done follows.
5. Abort: req3 with len=8 dropped after the counter reads 3 → counter clears to 0 next edge, no done_o, state returns to IDLE. The next pending requester is granted one edge later.
6. rstn low mid-RUN while the counter reads 4 → all outputs return to 0 and the counter clears. After release, req0 wins first because ptr is reset to NREQ-1.
